// File: rtl/cpu_pkg.sv
// Shared datapath widths, write-back select encodings and register index type
// for the write-back stage and register file.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_core.sv
// Register storage: one synchronous write port, three asynchronous read ports
// (rs, rt, dbg). Optionally hardwires register 0 to zero.
module regfile_core #(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NumRegs];
  logic              wr_en;

  assign wr_en = we_i && !(ZERO_REG && (waddr_i == '0));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rs_data_o  = (ZERO_REG && (rs_addr_i == '0))  ? '0 : mem_q[rs_addr_i];
  assign rt_data_o  = (ZERO_REG && (rt_addr_i == '0))  ? '0 : mem_q[rt_addr_i];
  assign dbg_data_o = (ZERO_REG && (dbg_addr_i == '0)) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: selects the WB value, commits it to the register file,
// bypasses same-cycle writes to the decode read ports, latches halt and counts commits.
module writeback_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
  parameter bit          ZERO_REG = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              regwrite_i,
  input  logic              write_data_control_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic              memread_i,
  input  logic              done_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] dbg_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_we_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  write_count_o,
  output logic [CNT_W-1:0]  load_count_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              halted_q;
  logic [CNT_W-1:0]  write_cnt_q, write_cnt_d;
  logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
  logic [DATA_W-1:0] wb_data;
  logic              we;
  logic [DATA_W-1:0] core_rs, core_rt;

  assign wb_data = (write_data_control_i == WB_SEL_MEM) ? q_i : alu_result_i;
  assign we      = regwrite_i && !halted_q && !(ZERO_REG && (write_addr_i == '0));

  regfile_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_core (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .we_i      (we),
    .waddr_i   (write_addr_i),
    .wdata_i   (wb_data),
    .rs_addr_i (rs_addr_i),
    .rt_addr_i (rt_addr_i),
    .dbg_addr_i(dbg_addr_i),
    .rs_data_o (core_rs),
    .rt_data_o (core_rt),
    .dbg_data_o(dbg_data_o)
  );

  // Write-first bypass; we is never set for a hardwired r0, so r0 stays zero here too.
  assign rs_data_o = (we && (rs_addr_i == write_addr_i)) ? wb_data : core_rs;
  assign rt_data_o = (we && (rt_addr_i == write_addr_i)) ? wb_data : core_rt;

  always_comb begin
    write_cnt_d = write_cnt_q;
    load_cnt_d  = load_cnt_q;
    if (we && (write_cnt_q != CntMax)) begin
      write_cnt_d = write_cnt_q + CNT_W'(1);
    end
    if (we && memread_i && (load_cnt_q != CntMax)) begin
      load_cnt_d = load_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      halted_q    <= 1'b0;
      write_cnt_q <= '0;
      load_cnt_q  <= '0;
    end else begin
      if (done_i) begin
        halted_q <= 1'b1;
      end
      write_cnt_q <= write_cnt_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  assign wb_data_o     = wb_data;
  assign wb_we_o       = we;
  assign halted_o      = halted_q;
  assign write_count_o = write_cnt_q;
  assign load_count_o  = load_cnt_q;

endmodule
